// File: rtl/aes_req_sched_pkg.sv
// Shared types and constants for the AES request scheduler.
// Also carries the FIPS-197 known-answer vectors.
package aes_req_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned BLOCK_W = 128;

   localparam logic [BLOCK_W-1:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [BLOCK_W-1:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [BLOCK_W-1:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   localparam logic [BLOCK_W-1:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [BLOCK_W-1:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [BLOCK_W-1:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

endpackage

// File: rtl/aes_req_sched_if.sv
// Request/response bundle between the requester fabric and aes_req_sched.
interface aes_req_sched_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   import aes_req_sched_pkg::*;

   localparam int unsigned IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*BLOCK_W-1:0] req_data;
   logic [NUM_REQ*BLOCK_W-1:0] req_key;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [BLOCK_W-1:0]         rsp_data;
   logic [IDW-1:0]             rsp_id;

   modport master (
      output req_valid, req_data, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_data, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/aes_core.sv
// Fully combinational AES-128 encryption; S-box computed as GF(2^8) inverse plus affine map.
module aes_core (
   input  logic [127:0] pt_i,
   input  logic [127:0] key_i,
   output logic [127:0] ct_o
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // b^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = b;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
      n0 = rk[127:96] ^ t;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Byte k of the block is state element (row k%4, column k/4)
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] s;
      logic [127:0] rk;
      logic [7:0]   rc;
      rk = key;
      rc = 8'h01;
      s  = pt ^ rk;
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox(s[8*i +: 8]);
         s = shift_rows(s);
         if (r < 10) s = mix_columns(s);
         rk = next_key(rk, rc);
         rc = xtime(rc);
         s  = s ^ rk;
      end
      return s;
   endfunction

   always_comb begin
      ct_o = encrypt(pt_i, key_i);
   end

endmodule

// File: rtl/aes_req_pick.sv
// Combinational grant picker: round-robin from ptr_i+1 when AES_REQ_SCHED_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module aes_req_pick #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
`ifdef AES_REQ_SCHED_RR_EN
   input  logic [IDW-1:0]     ptr_i,
`endif
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     gnt_idx_o,
   output logic               gnt_any_o
);

   assign gnt_any_o = |req_valid_i;

`ifdef AES_REQ_SCHED_RR_EN
   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((32'(ptr_i) + k) % NUM_REQ);
         if (!found && req_valid_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end
`else
   // Descending scan so the lowest asserted index is the last to write
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            gnt_o     = '0;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = IDW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/aes_req_sched.sv
// Shares one combinational aes_core among NUM_REQ requesters with a multicycle settle window.
// AES_REQ_SCHED_RR_EN selects round-robin arbitration; otherwise fixed priority.
module aes_req_sched #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned SETTLE_CYCLES = 3,
   localparam int unsigned IDW          = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   aes_req_sched_if.slave        bus,
   output logic                  busy
);
   import aes_req_sched_pkg::*;

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] pt_q, pt_d, key_q, key_d;
   logic [BLOCK_W-1:0] rsp_data_q, rsp_data_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [BLOCK_W-1:0] ct, sel_data, sel_key;
   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any, accept;
`ifdef AES_REQ_SCHED_RR_EN
   logic [IDW-1:0]     ptr_q, ptr_d;
`endif

   aes_req_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_pick (
      .req_valid_i(bus.req_valid),
`ifdef AES_REQ_SCHED_RR_EN
      .ptr_i      (ptr_q),
`endif
      .gnt_o      (gnt),
      .gnt_idx_o  (gnt_idx),
      .gnt_any_o  (gnt_any)
   );

   // Operand registers are the launch point of the multicycle paths through the core
   aes_core u_core (
      .pt_i (pt_q),
      .key_i(key_q),
      .ct_o (ct)
   );

   always_comb begin
      sel_data = '0;
      sel_key  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gnt[i]) begin
            sel_data = sel_data | bus.req_data[i*BLOCK_W +: BLOCK_W];
            sel_key  = sel_key | bus.req_key[i*BLOCK_W +: BLOCK_W];
         end
      end
   end

   assign bus.req_ready = (state_q == StIdle && !rst) ? gnt : '0;
   assign accept        = (state_q == StIdle) && gnt_any && !rst;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pt_d        = pt_q;
      key_d       = key_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
`ifdef AES_REQ_SCHED_RR_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         StIdle: begin
            if (accept) begin
               pt_d     = sel_data;
               key_d    = sel_key;
               rsp_id_d = gnt_idx;
               cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
               state_d  = StRun;
`ifdef AES_REQ_SCHED_RR_EN
               ptr_d    = gnt_idx;
`endif
            end
         end
         StRun: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_data_d  = ct;
               rsp_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pt_q        <= '0;
         key_q       <= '0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
`ifdef AES_REQ_SCHED_RR_EN
         ptr_q       <= IDW'(NUM_REQ - 1);
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pt_q        <= pt_d;
         key_q       <= key_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef AES_REQ_SCHED_RR_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign busy          = (state_q != StIdle);

endmodule
